// File: rtl/tt_um_noritsuna_count_uart_tx_if.sv
// tt_um_noritsuna_count_uart_tx_if: pin bundle between the UART transmitter and its driver
interface tt_um_noritsuna_count_uart_tx_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_noritsuna_count_uart_tx.sv
// tt_um_noritsuna_count_uart_tx: strobe-started UART 8N1 transmitter; define COUNT_UART_PARITY_EN for 8E1
module tt_um_noritsuna_count_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input logic clk,
  input logic rst_n,
  tt_um_noritsuna_count_uart_tx_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef COUNT_UART_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  sync_q;
  logic [1:0]  vld_q;
  logic        armed_q, armed_d;
  logic        done_q, done_d;
  logic        pend_q, pend_d;
`ifdef COUNT_UART_PARITY_EN
  logic        par_q, par_d;
`endif
  logic        start_req, tick, tx, busy;

  // A rising edge counts only once the strobe has really been sampled low
  // after reset, so a strobe held high through reset release starts nothing.
  assign start_req = sync_q[1] & ~sync_q[2] & armed_q;
  assign armed_d   = armed_q | (vld_q[1] & ~sync_q[1]);
  assign tick      = cnt_q == LAST;
  assign busy      = state_q != IDLE;

  assign bus.uo_out  = {5'b0, done_q, busy, tx};
  assign bus.uio_out = {4'b0, state_q, 1'b0};
  assign bus.uio_oe  = 8'b0000_1110;

  // Line level: derived from state so reset drives idle-high immediately
  always_comb begin
    tx = 1'b1;
    if (state_q == START) tx = 1'b0;
    if (state_q == DATA) tx = shift_q[0];
`ifdef COUNT_UART_PARITY_EN
    if (state_q == PARITY) tx = par_q;
`endif
  end

  // Next state: bit-period counter restarts on every boundary; an edge seen
  // during the done cycle is held one cycle so frames never abut
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    pend_d  = 1'b0;
`ifdef COUNT_UART_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q == IDLE) begin
      cnt_d  = '0;
      bit_d  = '0;
      pend_d = start_req & done_q;
      if ((start_req | pend_q) & ~done_q) begin
        state_d = START;
        shift_d = bus.ui_in;
`ifdef COUNT_UART_PARITY_EN
        par_d   = ^bus.ui_in;
`endif
      end
    end else begin
      cnt_d = tick ? '0 : cnt_q + 16'd1;
      if (tick) begin
        case (state_q)
          START: state_d = DATA;
          DATA: begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
`ifdef COUNT_UART_PARITY_EN
            if (bit_q == 3'd7) state_d = PARITY;
          end
          PARITY: state_d = STOP;
`else
            if (bit_q == 3'd7) state_d = STOP;
          end
`endif
          STOP: begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // State register: ena low freezes everything including the synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sync_q  <= '0;
      vld_q   <= '0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
`ifdef COUNT_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (bus.ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sync_q  <= {sync_q[1:0], bus.uio_in[0]};
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
`ifdef COUNT_UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_tt_um_noritsuna_count_uart_tx.sv
// tb_tt_um_noritsuna_count_uart_tx: randomized frame checks against a bit-list model
module tb_tt_um_noritsuna_count_uart_tx;
  localparam int C = 4;
`ifdef COUNT_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tt_um_noritsuna_count_uart_tx_if bus();

  tt_um_noritsuna_count_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Frame as a bit list, index 0 first on the wire
  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef COUNT_UART_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b11, b, 1'b0};
`endif
  endfunction

  function automatic logic [2:0] state_of(input int k);
    int n = k / C;
    if (n == 0) return 3'd1;
    if (n <= 8) return 3'd2;
    if (NB == 11 && n == 9) return 3'd3;
    return 3'd4;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      step;
      check("idle_tx", bus.uo_out[0], 1'b1);
      check("idle_busy", bus.uo_out[1], 1'b0);
    end
  endtask

  task automatic frame(input logic [7:0] b, input int inj, input logic [7:0] nb, input int fz, input int fzn);
    logic [10:0] fv = frame_of(b);
    bus.ui_in = b;
    bus.uio_in[0] = 1'b1;
    step;
    check("pre1_tx", bus.uo_out[0], 1'b1);
    bus.uio_in[0] = 1'b0;
    step;
    check("pre2_busy", bus.uo_out[1], 1'b0);
    for (int k = 0; k < F; k++) begin
      step;
      check("tx", bus.uo_out[0], fv[k / C]);
      check("busy", bus.uo_out[1], 1'b1);
      check("state", bus.uio_out[3:1], state_of(k));
      if (k == inj) begin
        bus.uio_in[0] = 1'b1;
        bus.ui_in = nb;
      end
      if (k == inj + 1) bus.uio_in[0] = 1'b0;
      if (k == fz) begin
        bus.ena = 1'b0;
        repeat (fzn) begin
          step;
          check("frz_tx", bus.uo_out[0], fv[k / C]);
          check("frz_busy", bus.uo_out[1], 1'b1);
        end
        bus.ena = 1'b1;
      end
    end
    step;
    check("done_hi", bus.uo_out[2], 1'b1);
    check("end_busy", bus.uo_out[1], 1'b0);
    check("end_state", bus.uio_out[3:1], 3'd0);
    step;
    check("done_lo", bus.uo_out[2], 1'b0);
  endtask

  initial begin
    bus.ena = 1'b1;
    bus.ui_in = 8'h00;
    bus.uio_in = 8'h00;
    #1;
    check("rst_tx", bus.uo_out[0], 1'b1);
    check("rst_busy", bus.uo_out[1], 1'b0);
    check("rst_done", bus.uo_out[2], 1'b0);
    check("rst_state", bus.uio_out[3:1], 3'd0);
    check("uo_hi", bus.uo_out[7:3], 5'd0);
    check("uio_oe", bus.uio_oe, 8'h0E);
    check("uio_out", {bus.uio_out[7:4], bus.uio_out[0]}, 5'd0);
    repeat (3) step;
    rst_n = 1'b1;
    idle(4);
    frame(8'hA5, -1, 8'h00, -1, 0);
    idle(3);
    frame(8'hA5, 10, 8'hFF, -1, 0);
    idle(10);
    frame(8'hA5, -1, 8'h00, 2 * C + 1, 7);
    idle(3);
    frame(8'h01, -1, 8'h00, -1, 0);
    idle(3);
    bus.ui_in = 8'h3C;
    bus.uio_in[0] = 1'b1;
    step;
    bus.uio_in[0] = 1'b0;
    repeat (18) step;
    check("mid_busy", bus.uo_out[1], 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_tx", bus.uo_out[0], 1'b1);
    check("abort_busy", bus.uo_out[1], 1'b0);
    check("abort_state", bus.uio_out[3:1], 3'd0);
    bus.uio_in[0] = 1'b1;
    repeat (3) begin
      step;
      check("abort_done", bus.uo_out[2], 1'b0);
    end
    rst_n = 1'b1;
    idle(20);
    bus.uio_in[0] = 1'b0;
    idle(4);
    for (int i = 0; i < 25; i++) begin
      int inj = ($urandom_range(1) == 1) ? int'($urandom_range(F - 6, 2)) : -1;
      int fz = ($urandom_range(1) == 1) ? int'($urandom_range(F - 1, 0)) : -1;
      frame(8'($urandom), inj, 8'($urandom), fz, int'($urandom_range(5, 1)));
      idle(int'($urandom_range(4, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tt_um_noritsuna_count_uart_tx.md
TT_UM_NORITSUNA_COUNT_UART_TX -- requirements
Module: tt_um_noritsuna_count_uart_tx

Interface
REQ-001 SHALL provide parameter: CLKS_PER_BIT, 16, clk cycles per UART bit period (legal 2..65535).
REQ-002 SHALL provide port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: ena  input  1  design enable; 0 freezes all state except reset.
REQ-005 SHALL provide port: ui_in  input  8  byte to send (8-bit counter value from upstream stage).
REQ-006 SHALL provide port: uo_out  output  8  [0] tx line, [1] busy, [2] done pulse, [7:3] constant 0.
REQ-007 SHALL provide port: uio_in  input  8  [0] send strobe (asynchronous to clk), [7:1] ignored.
REQ-008 SHALL provide port: uio_out  output  8  [3:1] FSM state code, all other bits constant 0.
REQ-009 SHALL provide port: uio_oe  output  8  constant 8'b0000_1110.

Function
REQ-010 SHALL pass uio_in[0] through a 2-flop synchronizer plus a third flop; start request = sync2 & ~sync3 (rising edge only).
REQ-011 SHALL implement FSM IDLE(0) -> START(1) -> DATA(2) -> [PARITY(3)] -> STOP(4) -> IDLE; code driven on uio_out[3:1].
REQ-012 SHALL, in IDLE on start request, latch ui_in into the shift register and enter START on the same edge; tx falls at the 3rd rising edge after the first edge sampling strobe high.
REQ-013 SHALL hold each bit on tx for exactly CLKS_PER_BIT cycles via a 16-bit bit-period counter reset on every bit boundary.
REQ-014 SHALL send frame: start bit 0, 8 data bits LSB first, optional parity bit, stop bit 1; frame = 10*CLKS_PER_BIT cycles (11 with parity).
REQ-015 SHALL drive tx = 1 whenever in IDLE.
REQ-016 SHALL assert busy in every state except IDLE, including the STOP bit.
REQ-017 SHALL pulse done high for exactly one cycle on the edge STOP -> IDLE.
REQ-018 SHALL ignore (not queue) start requests arriving while busy; ui_in changes after latch SHALL NOT affect the frame in flight.
REQ-019 SHALL accept a strobe edge detected in the same cycle done is high only from the following IDLE cycle (no back-to-back frame without at least one IDLE cycle).
REQ-020 SHALL, when ena=0, hold FSM, counters, shift register, synchronizer and outputs unchanged; resume exactly where frozen when ena=1.

Reset
REQ-021 SHALL, while rst_n=0, force state IDLE, tx=1, busy=0, done=0, counters 0, synchronizer flops 0, shift register 0, independent of clk.
REQ-022 SHALL abort any frame in progress on reset (tx returns to 1 immediately, no done pulse).
REQ-023 SHALL release reset with tx idle-high; a strobe held high across reset release SHALL NOT start a frame (sync flops reset low, edge requires a low-to-high transition sampled after release... first edge with sync flops low counts as a rising edge only if strobe is subsequently seen low then high).

Configuration
REQ-024 SHALL, with macro COUNT_UART_PARITY_EN defined, insert an even-parity bit (XOR of the 8 latched data bits) between DATA and STOP, using state PARITY(3), frame 11*CLKS_PER_BIT.
REQ-025 SHALL, without COUNT_UART_PARITY_EN, omit PARITY state and logic entirely (DATA -> STOP directly, 8N1).

Verification
REQ-026 SHALL cover: CLKS_PER_BIT=4, ui_in=0xA5, strobe pulse -> tx = 0,1,0,1,0,0,1,0,1,1 each 4 cycles, busy high 40 cycles, done high 1 cycle.
REQ-027 SHALL cover: second strobe 10 cycles into a frame with ui_in changed to 0xFF -> frame still carries 0xA5, no second frame follows.
REQ-028 SHALL cover: rst_n low 17 cycles into a frame -> tx=1, busy=0, state 0 immediately (async), no done pulse.
REQ-029 SHALL cover: ena=0 for 7 cycles mid DATA bit -> that bit lasts 4+7 cycles on tx, remaining frame unchanged.
REQ-030 SHALL cover: COUNT_UART_PARITY_EN defined, ui_in=0xA5 -> parity bit 0; ui_in=0x01 -> parity bit 1; busy high 44 cycles.
